muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only while idle.
REQ-005 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port rs1_data  input  32  operand A, from register-file read port 1.
REQ-007 SHALL have port rs2_data  input  32  operand B, from register-file read port 2.
REQ-008 SHALL have port rd_addr  input  5  destination register.
REQ-009 SHALL have port busy  output  1  unit not idle.
REQ-010 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port result  output  32  result, valid while done=1.
REQ-012 SHALL have port wb_addr  output  5  captured rd_addr, feeds register-file write address.
REQ-013 SHALL have port wb_ena  output  1  write enable toward register file.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIN; busy = (state != IDLE).
REQ-015 SHALL, in IDLE with start=1, capture op, operands and rd_addr, then enter CALC; start in CALC/FIN is ignored.
REQ-016 SHALL perform one radix-2 iteration per CALC cycle, 32 cycles (shift-add multiply on 64-bit accumulator; restoring divide on operand magnitudes).
REQ-017 SHALL enter FIN after the 32nd CALC cycle, apply sign correction, and assert done for exactly that one cycle, then return to IDLE.
REQ-018 SHALL give latency: start sampled at edge k -> done=1 in cycle after edge k+33; next start accepted from edge k+34.
REQ-019 SHALL return low 32 bits for MUL, high 32 bits for MULH/MULHSU/MULHU with signed x signed, signed x unsigned, unsigned x unsigned respectively.
REQ-020 SHALL truncate division toward zero; remainder takes dividend sign.
REQ-021 SHALL, on divide by zero, go IDLE->FIN directly (done in cycle after edge k+1): DIV/DIVU = 0xFFFFFFFF, REM/REMU = rs1_data.
REQ-022 SHALL, on DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF, go IDLE->FIN directly: DIV = 0x80000000, REM = 0.
REQ-023 SHALL drive wb_ena = done AND (wb_addr != 0); never write x0.
REQ-024 SHALL hold result and wb_addr stable from FIN until the next FIN; result content outside done is don't-care.

Reset
REQ-025 SHALL, on rst=1 at any edge (including mid-CALC), enter IDLE, discard the operation, and drive busy=0, done=0, wb_ena=0, result=0, wb_addr=0, iteration counter=0.
REQ-026 SHALL give rst priority over start in the same cycle.

Configuration
REQ-027 SHALL, with RV32M_DIV_EN defined, implement all eight ops as above.
REQ-028 SHALL, without RV32M_DIV_EN, remove divider datapath; ops 100-111 go IDLE->FIN with result=0, done=1, wb_ena=0 (no write-back); multiply ops unchanged.

Structure
REQ-029 SHALL place op encodings, FSM state encoding and iteration count (32) in shared package muldiv_pkg.
REQ-030 SHALL isolate the per-cycle add/subtract-and-shift datapath in sub-module muldiv_iter; FSM, counter and sign fixup stay in muldiv_unit.

Verification
REQ-031 SHALL cover MUL 7 x -3, rd=5 -> done at k+33, result 0xFFFFFFEB, wb_addr=5, wb_ena=1.
REQ-032 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-033 SHALL cover DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-034 SHALL cover DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, plus DIV 0x80000000/-1 -> 0x80000000, each with done at k+1.
REQ-035 SHALL cover start asserted mid-CALC ignored, rst at CALC cycle 10 -> next cycle busy=0, done=0, result=0, then fresh MUL 3 x 4 -> 12.
REQ-036 SHALL cover rd_addr=0 -> done=1, wb_ena=0; and, without RV32M_DIV_EN, DIVU 9/3 -> done at k+1, result 0, wb_ena=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the RV32M multiply/divide unit.
//   op_e        RV32M funct3 encodings
//   state_e     control FSM states
//   ITER_COUNT  radix-2 iterations per operation
//   signed_a / signed_b  operand signedness per op
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } state_e;

  localparam int unsigned ITER_COUNT = 32;

  function automatic logic signed_a(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic signed_b(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one radix-2 step of the multiply/divide datapath (combinational).
//   is_div   1 = restoring-divide step, 0 = shift-add multiply step
//   acc_in   64-bit accumulator {hi, lo}
//   operand  multiplicand (multiply) or divisor magnitude (divide)
//   acc_out  accumulator after this step
// Optional feature macro: RV32M_DIV_EN (divide step present only when defined).
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                is_div,
  input  logic [2*XLEN-1:0]   acc_in,
  input  logic [XLEN-1:0]     operand,
  output logic [2*XLEN-1:0]   acc_out
);

  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] mul_out;

  // Multiply: lo holds the remaining multiplier bits; add into hi when the
  // current LSB is set, then shift the whole accumulator (with carry) right.
  always_comb begin
    sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, operand};
    if (acc_in[0]) begin
      mul_out = {sum, acc_in[XLEN-1:1]};
    end else begin
      mul_out = {1'b0, acc_in[2*XLEN-1:1]};
    end
  end

`ifdef RV32M_DIV_EN
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] div_out;

  // Divide: hi is the partial remainder, lo shifts the dividend out and the
  // quotient bits in. Trial subtract on the shifted remainder; keep it if
  // non-negative.
  always_comb begin
    diff = acc_in[2*XLEN-1:XLEN-1] - {1'b0, operand};
    if (!diff[XLEN]) begin
      div_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
    end else begin
      div_out = {acc_in[2*XLEN-2:0], 1'b0};
    end
  end

  assign acc_out = is_div ? div_out : mul_out;
`else
  logic unused_is_div;
  assign unused_is_div = is_div;
  assign acc_out       = mul_out;
`endif

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with register-file write-back.
//   clk, rst            clock, synchronous active-high reset
//   start, op           request (sampled only in IDLE) and RV32M funct3
//   rs1_data, rs2_data  operands A and B
//   rd_addr             destination register
//   busy                unit not idle
//   done                one-cycle result-valid pulse
//   result              result, held until the next completion
//   wb_addr, wb_ena     register-file write address / enable (never x0)
// Optional feature macro: RV32M_DIV_EN (divide/remainder ops). Without it,
// divide ops complete immediately with result 0 and no write-back.
// done/result/wb_* are registered on the FIN->IDLE edge, so the done cycle
// is already IDLE and a new start is accepted on the following edge.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_addr,
  output logic            wb_ena
);

  localparam logic [4:0] LAST_ITER = 5'(ITER_COUNT - 1);

  state_e            state;
  op_e               op_q;
  logic [4:0]        cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   opnd;
  logic              a_sgn_q, b_sgn_q;
  logic              spec_q, wr_q;
  logic [XLEN-1:0]   spec_res_q;
  logic [4:0]        rd_q;

  logic              a_sgn, b_sgn;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              spec;
  logic              spec_wr;
  logic [XLEN-1:0]   spec_res;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fix_res;

  assign busy = (state != IDLE);

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .is_div  (op_q[2]),
    .acc_in  (acc),
    .operand (opnd),
    .acc_out (acc_next)
  );

  // Request decode: operand magnitudes and single-cycle special cases.
  always_comb begin
    a_sgn = rs1_data[XLEN-1] & signed_a(op_e'(op));
    b_sgn = rs2_data[XLEN-1] & signed_b(op_e'(op));
    a_mag = a_sgn ? (~rs1_data + XLEN'(1)) : rs1_data;
    b_mag = b_sgn ? (~rs2_data + XLEN'(1)) : rs2_data;
    spec     = 1'b0;
    spec_wr  = 1'b1;
    spec_res = '0;
`ifdef RV32M_DIV_EN
    if (op[2] && (rs2_data == '0)) begin
      spec     = 1'b1;
      spec_res = op[1] ? rs1_data : '1;
    end else if (op[2] && !op[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (rs2_data == '1)) begin
      spec     = 1'b1;
      spec_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
`else
    if (op[2]) begin
      spec    = 1'b1;
      spec_wr = 1'b0;
    end
`endif
  end

  // Sign correction of the magnitude result.
  always_comb begin
    prod    = (a_sgn_q ^ b_sgn_q) ? (~acc + (2*XLEN)'(1)) : acc;
    fix_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef RV32M_DIV_EN
    if (op_q[2]) begin
      if (op_q[1]) begin
        fix_res = a_sgn_q ? (~acc[2*XLEN-1:XLEN] + XLEN'(1)) : acc[2*XLEN-1:XLEN];
      end else begin
        fix_res = (a_sgn_q ^ b_sgn_q) ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_MUL;
      cnt        <= '0;
      acc        <= '0;
      opnd       <= '0;
      a_sgn_q    <= 1'b0;
      b_sgn_q    <= 1'b0;
      spec_q     <= 1'b0;
      wr_q       <= 1'b0;
      spec_res_q <= '0;
      rd_q       <= '0;
      done       <= 1'b0;
      result     <= '0;
      wb_addr    <= '0;
      wb_ena     <= 1'b0;
    end else begin
      done   <= 1'b0;
      wb_ena <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q       <= op_e'(op);
            acc        <= {{XLEN{1'b0}}, a_mag};
            opnd       <= b_mag;
            a_sgn_q    <= a_sgn;
            b_sgn_q    <= b_sgn;
            spec_q     <= spec;
            wr_q       <= spec ? spec_wr : 1'b1;
            spec_res_q <= spec_res;
            rd_q       <= rd_addr;
            cnt        <= '0;
            state      <= spec ? FIN : CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == LAST_ITER) begin
            state <= FIN;
          end
        end
        FIN: begin
          done    <= 1'b1;
          result  <= spec_q ? spec_res_q : fix_res;
          wb_addr <= rd_q;
          wb_ena  <= wr_q && (rd_q != 5'd0);
          cnt     <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  wb_addr;
  logic        wb_ena;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_addr  (rd_addr),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .wb_addr  (wb_addr),
    .wb_ena   (wb_ena)
  );

`ifdef RV32M_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // Reference model: plain 64-bit arithmetic and SV integer division.
  function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] a, b);
    logic [63:0] a64, b64, p;
    int sa, sb;
    sa = a;
    sb = b;
    if (!o[2]) begin
      a64 = (o == 3'd3) ? {32'd0, a} : {{32{a[31]}}, a};
      b64 = (o == 3'd0 || o == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
      p = a64 * b64;
      return (o == 3'd0) ? p[31:0] : p[63:32];
    end
    if (!DIV_EN) return 32'd0;
    if (b == 32'd0) return (o[1]) ? a : 32'hFFFF_FFFF;
    case (o)
      3'd4: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return a / b;
      3'd6: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, b);
    if (!o[2]) return 33;
    if (!DIV_EN) return 1;
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic model_we(input logic [2:0] o, input logic [4:0] rd);
    return (rd != 5'd0) && (!o[2] || DIV_EN);
  endfunction

  // Drive one request and wait (bounded) for done; lat = -1 on timeout.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, b, input logic [4:0] rd,
                       output int lat, output logic [31:0] res, output logic [4:0] wa,
                       output logic we);
    @(negedge clk);
    op = o; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom; rd_addr = 5'($urandom);
    lat = -1; res = 'x; wa = 'x; we = 1'bx;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n; res = result; wa = wb_addr; we = wb_ena;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy, done, wb_ena} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got=%b want=000", {busy, done, wb_ena});
    end
    n_vec++;
    if (result !== 32'd0 || wb_addr !== 5'd0) begin
      n_err++; $display("FAIL reset_outputs result=%h wb_addr=%0d want 0/0", result, wb_addr);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  task automatic test_directed_mul();
    vec_t v[4];
    int lat; logic [31:0] res; logic [4:0] wa; logic we;
    v[0] = '{3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB};
    v[1] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000};
    v[2] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE};
    v[3] = '{3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF};
    foreach (v[i]) begin
      issue(v[i].o, v[i].a, v[i].b, v[i].rd, lat, res, wa, we);
      n_vec++;
      if (lat !== 33 || res !== v[i].exp) begin
        n_err++; $display("FAIL mul_dir%0d lat=%0d res=%h want lat=33 res=%h", i, lat, res, v[i].exp);
      end
      n_vec++;
      if (wa !== v[i].rd || we !== 1'b1) begin
        n_err++; $display("FAIL mul_dir%0d_wb addr=%0d ena=%b want %0d/1", i, wa, we, v[i].rd);
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0 || result !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL done_pulse_hold done=%b result=%h want 0/ffffffff", done, result);
    end
  endtask

  task automatic test_directed_div();
    vec_t v[7];
    int lat; logic [31:0] res; logic [4:0] wa; logic we;
    int elat;
    v[0] = '{3'd4, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD};
    v[1] = '{3'd6, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF};
    v[2] = '{3'd5, 32'd100, 32'd7, 5'd3, 32'd14};
    v[3] = '{3'd7, 32'd100, 32'd7, 5'd4, 32'd2};
    v[4] = '{3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF};
    v[5] = '{3'd6, 32'd5, 32'd0, 5'd10, 32'd5};
    v[6] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
    foreach (v[i]) begin
      issue(v[i].o, v[i].a, v[i].b, v[i].rd, lat, res, wa, we);
      elat = (i >= 4) ? 1 : 33;
      n_vec++;
      if (lat !== elat || res !== v[i].exp || we !== 1'b1) begin
        n_err++;
        $display("FAIL div_dir%0d lat=%0d res=%h ena=%b want lat=%0d res=%h ena=1",
                 i, lat, res, we, elat, v[i].exp);
      end
    end
  endtask

  task automatic test_div_disabled();
    int lat; logic [31:0] res; logic [4:0] wa; logic we;
    issue(3'd5, 32'd9, 32'd3, 5'd12, lat, res, wa, we);
    n_vec++;
    if (lat !== 1 || res !== 32'd0 || we !== 1'b0) begin
      n_err++; $display("FAIL divu_disabled lat=%0d res=%h ena=%b want 1/0/0", lat, res, we);
    end
  endtask

  task automatic test_rd_zero();
    int lat; logic [31:0] res; logic [4:0] wa; logic we;
    issue(3'd0, 32'd6, 32'd7, 5'd0, lat, res, wa, we);
    n_vec++;
    if (lat !== 33 || res !== 32'd42 || wa !== 5'd0 || we !== 1'b0) begin
      n_err++; $display("FAIL rd_zero lat=%0d res=%h addr=%0d ena=%b want 33/2a/0/0", lat, res, wa, we);
    end
  endtask

  task automatic test_mid_start_and_reset();
    int lat; logic [31:0] res; logic [4:0] wa; logic we;
    // Spurious start during CALC must not disturb the running op.
    @(negedge clk);
    op = 3'd0; rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD; rd_addr = 5'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL busy_calc got=%b want 1", busy);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    op = 3'd3; rs1_data = 32'h1234_5678; rs2_data = 32'h9ABC_DEF0; rd_addr = 5'd9; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n; res = result; wa = wb_addr;
        break;
      end
    end
    n_vec++;
    if (lat < 0 || res !== 32'hFFFF_FFEB || wa !== 5'd5) begin
      n_err++; $display("FAIL mid_start lat=%0d res=%h addr=%0d want ffffffeb/5", lat, res, wa);
    end
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL mid_start_after busy=%b done=%b want 0/0", busy, done);
    end
    // Reset during CALC cycle 10 abandons the op.
    @(negedge clk);
    op = 3'd1; rs1_data = 32'd99; rs2_data = 32'd77; rd_addr = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || wb_addr !== 5'd0 || wb_ena !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_calc busy=%b done=%b result=%h wb_addr=%0d ena=%b want all 0",
               busy, done, result, wb_addr, wb_ena);
    end
    issue(3'd0, 32'd3, 32'd4, 5'd14, lat, res, wa, we);
    n_vec++;
    if (lat !== 33 || res !== 32'd12 || wa !== 5'd14 || we !== 1'b1) begin
      n_err++; $display("FAIL post_rst_mul lat=%0d res=%h addr=%0d ena=%b want 33/c/14/1", lat, res, wa, we);
    end
  endtask

  task automatic test_reset_start_priority();
    @(negedge clk);
    op = 3'd0; rs1_data = 32'd2; rs2_data = 32'd2; rd_addr = 5'd1; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL rst_over_start busy=%b want 0", busy);
    end
  endtask

  task automatic test_random_back_to_back();
    int lat; logic [31:0] res; logic [4:0] wa; logic we;
    logic [2:0] o; logic [31:0] a, b; logic [4:0] rd;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      rd = 5'($urandom);
      issue(o, a, b, rd, lat, res, wa, we);
      n_vec++;
      if (lat !== model_lat(o, a, b) || res !== model_res(o, a, b) ||
          wa !== rd || we !== model_we(o, rd)) begin
        n_err++;
        $display("FAIL rand%0d op=%0d a=%h b=%h rd=%0d got lat=%0d res=%h addr=%0d ena=%b want lat=%0d res=%h ena=%b",
                 i, o, a, b, rd, lat, res, wa, we, model_lat(o, a, b), model_res(o, a, b), model_we(o, rd));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed_mul();
    if (DIV_EN) test_directed_div();
    else        test_div_disabled();
    test_rd_zero();
    test_mid_start_and_reset();
    test_reset_start_priority();
    test_random_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
